m206_time_seq: RTL and testbench

//   Major timing sequencer for the processor's time-state/time-pulse flip-flop chain.

---
 rtl/m206_time_seq.sv | 117 +++++++++++
 tb/tb_m206_time_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m206_time_seq.sv
// Major timing sequencer: steps a memory cycle through TS1..TS4 and emits TP1..TP4 pulses.
// Optional single-step input enabled by defining TIMING_SSTEP_EN.
module m206_time_seq #(
    parameter int TS_CYCLES = 8,
    parameter int TP_WIDTH  = 2,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_req,
    input  logic       stop_req,
    input  logic       mem_done,
    input  logic       pause,
`ifdef TIMING_SSTEP_EN
    input  logic       sstep,
`endif
    output logic       run,
    output logic [3:0] ts,
    output logic [3:0] tp,
    output logic       mem_start
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TS1  = 3'd1,
        TS2  = 3'd2,
        TS3  = 3'd3,
        TS4  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_TP   = CNT_W'(TS_CYCLES - TP_WIDTH);
    localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(TS_CYCLES - TP_WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             stop_latch, stop_latch_nxt;
    logic             done, done_nxt;
    logic             sstep_i;
    logic             hold;

`ifdef TIMING_SSTEP_EN
    assign sstep_i = sstep;
`else
    assign sstep_i = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            stop_latch <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            stop_latch <= stop_latch_nxt;
            done       <= done_nxt;
        end
    end

    // Holds freeze the counter one step short of the pulse window
    assign hold = ((state == TS2) && !done) || ((state == TS3) && pause);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (run_req && !stop_req) begin
                    state_nxt = TS1;
                end
            end
            default: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    case (state)
                        TS1:     state_nxt = TS2;
                        TS2:     state_nxt = TS3;
                        TS3:     state_nxt = TS4;
                        default: state_nxt = (stop_latch || stop_req || sstep_i) ? IDLE : TS1;
                    endcase
                end else if (!(hold && (cnt == CNT_HOLD))) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        stop_latch_nxt = 1'b0;
        done_nxt       = 1'b0;
        if (state_nxt != IDLE) begin
            stop_latch_nxt = stop_latch || (run && stop_req);
        end
        // The memory-done flag only lives while the machine stays in TS2
        if ((state == TS2) && (state_nxt == TS2)) begin
            done_nxt = done || mem_done;
        end
    end

    always_comb begin
        ts = 4'b0000;
        case (state)
            TS1:     ts = 4'b0001;
            TS2:     ts = 4'b0010;
            TS3:     ts = 4'b0100;
            TS4:     ts = 4'b1000;
            default: ts = 4'b0000;
        endcase
        tp        = (cnt >= CNT_TP) ? ts : 4'b0000;
        run       = (state != IDLE);
        mem_start = (state == TS1) && (cnt == '0);
    end

endmodule

// File: tb/tb_m206_time_seq.sv
// Directed bench for m206_time_seq at TS_CYCLES=8, TP_WIDTH=2.
// Compares {run, ts, tp, mem_start} once per clock against hand-derived state/count pairs.
module tb_m206_time_seq;

    logic       clk;
    logic       reset;
    logic       run_req;
    logic       stop_req;
    logic       mem_done;
    logic       pause;
`ifdef TIMING_SSTEP_EN
    logic       sstep;
`endif
    logic       run;
    logic [3:0] ts;
    logic [3:0] tp;
    logic       mem_start;
    logic [9:0] vec;

    int errors;
    int checks;

    m206_time_seq #(
        .TS_CYCLES(8),
        .TP_WIDTH (2),
        .CNT_W    (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run_req  (run_req),
        .stop_req (stop_req),
        .mem_done (mem_done),
        .pause    (pause),
`ifdef TIMING_SSTEP_EN
        .sstep    (sstep),
`endif
        .run      (run),
        .ts       (ts),
        .tp       (tp),
        .mem_start(mem_start)
    );

    assign vec = {run, ts, tp, mem_start};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {run, ts, tp, mem_start} for time state s (0 = idle) and count c
    function automatic logic [9:0] exp_vec(input int s, input int c);
        logic [3:0] t;
        logic [3:0] p;
        logic       m;
        if (s == 0) return 10'b0;
        t = 4'b0001 << (s - 1);
        p = (c >= 6) ? t : 4'b0000;
        m = (s == 1) && (c == 0);
        return {1'b1, t, p, m};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cycle();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        run_req  = 1'b1;
        stop_req = 1'b0;
        mem_done = 1'b0;
        pause    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (vec !== 10'b0) begin
                errors++;
                $display("FAIL reset clk %0d: got %b want %b", i, vec, 10'b0);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if (vec !== exp_vec(1, 0)) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", vec, exp_vec(1, 0));
        end
        run_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (vec !== 10'b0) begin
            errors++;
            $display("FAIL reset_abort: got %b want %b", vec, 10'b0);
        end
        tick();
        checks++;
        if (vec !== 10'b0) begin
            errors++;
            $display("FAIL reset_idle: got %b want %b", vec, 10'b0);
        end
    endtask

    task automatic test_full_cycle();
        mem_done = 1'b1;
        start_cycle();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (vec !== exp_vec(i / 8 + 1, i % 8)) begin
                errors++;
                $display("FAIL full_cycle clk %0d: got %b want %b", i, vec, exp_vec(i / 8 + 1, i % 8));
            end
            stop_req = (i == 10);
            tick();
        end
        stop_req = 1'b0;
        checks++;
        if (vec !== 10'b0) begin
            errors++;
            $display("FAIL full_cycle_end: got %b want %b", vec, 10'b0);
        end
    endtask

    task automatic test_mem_hold();
        int c;
        mem_done = 1'b0;
        start_cycle();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (vec !== exp_vec(1, i)) begin
                errors++;
                $display("FAIL mem_ts1 clk %0d: got %b want %b", i, vec, exp_vec(1, i));
            end
            mem_done = 1'b1;
            tick();
        end
        for (int j = 0; j < 15; j++) begin
            c = (j < 5) ? j : ((j <= 12) ? 5 : j - 7);
            checks++;
            if (vec !== exp_vec(2, c)) begin
                errors++;
                $display("FAIL mem_ts2 clk %0d: got %b want %b", j, vec, exp_vec(2, c));
            end
            mem_done = (j == 11);
            tick();
        end
        mem_done = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (vec !== exp_vec(i / 8 + 3, i % 8)) begin
                errors++;
                $display("FAIL mem_ts34 clk %0d: got %b want %b", i, vec, exp_vec(i / 8 + 3, i % 8));
            end
            stop_req = (i == 15);
            tick();
        end
        stop_req = 1'b0;
        checks++;
        if (vec !== 10'b0) begin
            errors++;
            $display("FAIL mem_end: got %b want %b", vec, 10'b0);
        end
    endtask

    task automatic test_pause();
        int c;
        mem_done = 1'b1;
        start_cycle();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (vec !== exp_vec(i / 8 + 1, i % 8)) begin
                errors++;
                $display("FAIL pause_ts12 clk %0d: got %b want %b", i, vec, exp_vec(i / 8 + 1, i % 8));
            end
            pause = (i == 13);
            tick();
        end
        for (int j = 0; j < 12; j++) begin
            c = (j < 5) ? j : ((j <= 9) ? 5 : j - 4);
            checks++;
            if (vec !== exp_vec(3, c)) begin
                errors++;
                $display("FAIL pause_ts3 clk %0d: got %b want %b", j, vec, exp_vec(3, c));
            end
            pause = (j >= 5) && (j <= 8);
            tick();
        end
        pause = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (vec !== exp_vec(4, i)) begin
                errors++;
                $display("FAIL pause_ts4 clk %0d: got %b want %b", i, vec, exp_vec(4, i));
            end
            stop_req = (i == 7);
            tick();
        end
        stop_req = 1'b0;
        checks++;
        if (vec !== 10'b0) begin
            errors++;
            $display("FAIL pause_end: got %b want %b", vec, 10'b0);
        end
    endtask

    task automatic test_back_to_back();
        mem_done = 1'b1;
        start_cycle();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (vec !== exp_vec(i / 8 + 1, i % 8)) begin
                errors++;
                $display("FAIL b2b_first clk %0d: got %b want %b", i, vec, exp_vec(i / 8 + 1, i % 8));
            end
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (vec !== exp_vec(i / 8 + 1, i % 8)) begin
                errors++;
                $display("FAIL b2b_second clk %0d: got %b want %b", i, vec, exp_vec(i / 8 + 1, i % 8));
            end
            run_req  = (i < 31);
            stop_req = (i == 31);
            tick();
        end
        run_req  = 1'b0;
        stop_req = 1'b0;
        checks++;
        if (vec !== 10'b0) begin
            errors++;
            $display("FAIL b2b_stop_last: got %b want %b", vec, 10'b0);
        end
    endtask

    task automatic test_stop_idle();
        run_req  = 1'b1;
        stop_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (vec !== 10'b0) begin
                errors++;
                $display("FAIL idle_run_stop clk %0d: got %b want %b", i, vec, 10'b0);
            end
        end
        run_req = 1'b0;
        tick();
        stop_req = 1'b0;
        start_cycle();
        for (int i = 0; i < 33; i++) begin
            checks++;
            if (vec !== exp_vec((i / 8) % 4 + 1, i % 8)) begin
                errors++;
                $display("FAIL idle_stop_ignored clk %0d: got %b want %b", i, vec, exp_vec((i / 8) % 4 + 1, i % 8));
            end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (vec !== 10'b0) begin
            errors++;
            $display("FAIL idle_reset: got %b want %b", vec, 10'b0);
        end
    endtask

`ifdef TIMING_SSTEP_EN
    task automatic test_sstep();
        sstep    = 1'b1;
        mem_done = 1'b1;
        start_cycle();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (vec !== exp_vec(i / 8 + 1, i % 8)) begin
                errors++;
                $display("FAIL sstep clk %0d: got %b want %b", i, vec, exp_vec(i / 8 + 1, i % 8));
            end
            tick();
        end
        checks++;
        if (vec !== 10'b0) begin
            errors++;
            $display("FAIL sstep_end: got %b want %b", vec, 10'b0);
        end
        sstep = 1'b0;
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
`ifdef TIMING_SSTEP_EN
        sstep = 1'b0;
`endif
        test_reset();
        test_full_cycle();
        test_mem_hold();
        test_pause();
        test_back_to_back();
        test_stop_idle();
`ifdef TIMING_SSTEP_EN
        test_sstep();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
